// File: rtl/amp_descale.sv
// Divides a signed amplified sample by the gain-code constant with a serial restoring divider.
// Optional AMP_DESCALE_ROUND_EN rounds the quotient half away from zero instead of truncating.
module amp_descale #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  amp_in,
  input  logic [2:0]       gain_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] wave_out,
  output logic             sat
);

  localparam int unsigned CNT_W = $clog2(IN_W);
  localparam int unsigned DIV_W = 4;
  localparam int unsigned MAG_W = IN_W + 1;
  localparam logic [MAG_W-1:0] POS_LIM = MAG_W'((1 << (OUT_W - 1)) - 1);
  localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(1 << (OUT_W - 1));

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DIV_W-1:0]   rem_q, rem_d;
  logic [IN_W-1:0]    quo_q, quo_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               sign_q, sign_d;
  logic               in_ready_d, out_valid_d, sat_d;
  logic [OUT_W-1:0]   wave_d;
  logic [DIV_W-1:0]   rem_shift;
  logic [DIV_W:0]     trial;
  logic [MAG_W-1:0]   mag_r;

  function automatic logic [DIV_W-1:0] div_map(input logic [2:0] g);
    case (g)
      3'd0:    div_map = DIV_W'(1);
      3'd1:    div_map = DIV_W'(2);
      3'd2:    div_map = DIV_W'(4);
      3'd3:    div_map = DIV_W'(6);
      default: div_map = DIV_W'(8);
    endcase
  endfunction

  // State register; quo_q holds the dividend magnitude and fills with quotient bits from the LSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      sign_q    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      wave_out  <= '0;
      sat       <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      sign_q    <= sign_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      wave_out  <= wave_d;
      sat       <= sat_d;
    end
  end

  // Remainder never exceeds divisor-1 (<= 7), so its top bit can be shifted out safely.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    sign_d    = sign_q;
    wave_d    = wave_out;
    sat_d     = sat;
    mag_r     = '0;
    rem_shift = {rem_q[DIV_W-2:0], quo_q[IN_W-1]};
    trial     = {1'b0, rem_shift} - {1'b0, div_q};

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_d  = amp_in[IN_W-1];
          quo_d   = amp_in[IN_W-1] ? (~amp_in + IN_W'(1)) : amp_in;
          div_d   = div_map(gain_sel);
          rem_d   = '0;
          count_d = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        if (!trial[DIV_W]) begin
          rem_d = trial[DIV_W-1:0];
          quo_d = {quo_q[IN_W-2:0], 1'b1};
        end else begin
          rem_d = rem_shift;
          quo_d = {quo_q[IN_W-2:0], 1'b0};
        end
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(IN_W - 1)) begin
          state_d = DONE;
          mag_r   = {1'b0, quo_d};
`ifdef AMP_DESCALE_ROUND_EN
          if ({rem_d, 1'b0} >= {1'b0, div_q})
            mag_r = mag_r + MAG_W'(1);
`endif
          if (mag_r == '0) begin
            wave_d = '0;
            sat_d  = 1'b0;
          end else if (!sign_q) begin
            sat_d  = (mag_r > POS_LIM);
            wave_d = (mag_r > POS_LIM) ? POS_LIM[OUT_W-1:0] : mag_r[OUT_W-1:0];
          end else begin
            sat_d  = (mag_r > NEG_LIM);
            wave_d = (mag_r > NEG_LIM) ? NEG_LIM[OUT_W-1:0]
                                       : (~mag_r[OUT_W-1:0] + OUT_W'(1));
          end
        end
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_amp_descale.sv
// Self-checking bench for amp_descale: directed corner cases plus random samples vs an arithmetic model.
module tb_amp_descale;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] amp_in;
  logic [2:0]  gain_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] wave_out;
  logic        sat;

  int errors = 0;
  int checks = 0;

  amp_descale dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .amp_in   (amp_in),
    .gain_sel (gain_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .wave_out (wave_out),
    .sat      (sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: integer division of the magnitude, optional rounding, sign, clip to 16 bits.
  function automatic logic [16:0] model(input logic signed [31:0] a, input logic [2:0] g);
    longint d, mag, q, r, res;
    d   = (g == 3'd0) ? 1 : (g == 3'd1) ? 2 : (g == 3'd2) ? 4 : (g == 3'd3) ? 6 : 8;
    mag = (a < 0) ? -longint'(a) : longint'(a);
    q   = mag / d;
    r   = mag % d;
`ifdef AMP_DESCALE_ROUND_EN
    if (2 * r >= d) q++;
`endif
    res = (a < 0) ? -q : q;
    if (res > 32767)  return {1'b1, 16'h7fff};
    if (res < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(res)};
  endfunction

  // One transaction: accept, measure latency, compare result, optional backpressure, release.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [2:0] g, input int hold);
    logic [16:0] exp;
    logic [15:0] held;
    int n;
    exp = model(a, g);
    @(negedge clk);
    check({tag, ".in_ready"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1; amp_in = a; gain_sel = g;
    @(negedge clk);
    in_valid = 1'b0; amp_in = $urandom; gain_sel = 3'($urandom);
    check({tag, ".busy"}, 64'(in_ready), 64'(0));
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'(32));
    check({tag, ".wave"}, 64'($signed(wave_out)), 64'($signed(exp[15:0])));
    check({tag, ".sat"}, 64'(sat), 64'(exp[16]));
    held = wave_out;
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0]; amp_in = $urandom; gain_sel = 3'($urandom);
      @(negedge clk);
      if (i == hold - 1) begin
        check({tag, ".hold_valid"}, 64'(out_valid), 64'(1));
        check({tag, ".hold_wave"}, 64'(wave_out), 64'(held));
        check({tag, ".hold_ready"}, 64'(in_ready), 64'(0));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".release_valid"}, 64'(out_valid), 64'(0));
    check({tag, ".release_ready"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    logic [31:0] a;
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; amp_in = '0; gain_sel = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.in_ready", 64'(in_ready), 64'(1));
    check("rst.out_valid", 64'(out_valid), 64'(0));
    check("rst.wave", 64'(wave_out), 64'(0));
    check("rst.sat", 64'(sat), 64'(0));
    rst_n = 1'b1;

    do_op("p600", 32'd600, 3'd3, 0);
    check("p600.const", 64'($signed(wave_out)), 64'(100));
    do_op("n600", -32'sd600, 3'd3, 0);
    do_op("trunc9", 32'd9, 3'd3, 0);
    do_op("neg4", -32'sd4, 3'd4, 0);
    do_op("satpos", 32'd262144, 3'd0, 0);
    do_op("satneg", 32'h8000_0000, 3'd0, 0);
    do_op("edge", 32'd262136, 3'd4, 0);
    do_op("clamp7", 32'd800, 3'd7, 0);
    do_op("bp", 32'd12345, 3'd2, 10);
    do_op("after_bp", -32'sd7000, 3'd1, 0);
    do_op("zero", 32'd0, 3'd5, 0);

    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0: a = $urandom;
        1: a = 32'($urandom_range(0, 600000)) - 32'd300000;
        default: a = 32'($urandom_range(0, 24)) + ((i % 2 == 1) ? 32'hFFFC_0000 : 32'h0003_FFF0);
      endcase
      do_op($sformatf("rnd%0d", i), a, 3'($urandom_range(0, 7)), (i % 4 == 0) ? 3 : 0);
    end

    // Reset in the middle of a division.
    @(negedge clk);
    in_valid = 1'b1; amp_in = 32'd5000; gain_sel = 3'd1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst.in_ready", 64'(in_ready), 64'(1));
    check("midrst.out_valid", 64'(out_valid), 64'(0));
    check("midrst.wave", 64'(wave_out), 64'(0));
    check("midrst.sat", 64'(sat), 64'(0));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst.no_stale", 64'(seen), 64'(0));
    do_op("post_rst", 32'd640, 3'd4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
